// File: rtl/udp_receive_pkg.sv
// Shared definitions for the GMII UDP receive path: state encoding, protocol
// constants and a byte-extraction helper.
package udp_receive_pkg;

   localparam int unsigned BYTE_W       = 8;
   localparam int unsigned LEN_W        = 16;
   localparam int unsigned CRC_W        = 32;
   localparam int unsigned IDX_W        = 5;
   localparam int unsigned MAC_BYTES    = 14;
   localparam int unsigned HDR_BYTES    = 28;
   localparam int unsigned FCS_BYTES    = 4;
   localparam int unsigned MAX_PREAMBLE = 7;

   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
   localparam logic [7:0]  IP_VER_IHL     = 8'h45;
   localparam logic [31:0] CRC_RESIDUE    = 32'hC704DD7B;
   localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
   localparam logic [7:0]  SFD_BYTE       = 8'hD5;
   localparam logic [7:0]  BCAST_BYTE     = 8'hFF;
   localparam logic [15:0] UDP_HDR_LEN    = 16'd8;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_PREAMBLE = 4'd1,
      ST_MAC      = 4'd2,
      ST_HEADER   = 4'd3,
      ST_DATA     = 4'd4,
      ST_PAD_CRC  = 4'd5,
      ST_DROP     = 4'd6
   } rx_state_t;

   // Byte idx (0 = most significant, first on the wire) of a 48-bit MAC.
   function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
      logic [47:0] s;
      s = mac << {idx, 3'b000};
      return s[47:40];
   endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide Ethernet CRC-32 (poly 04C11DB7, LSB-first data, MSB-first register).
// init alone reloads all-ones; init with en folds d into a freshly seeded CRC.
module crc32_d8
   import udp_receive_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              init,
   input  logic              en,
   input  logic [BYTE_W-1:0] d,
   output logic [CRC_W-1:0]  crc
);

   localparam logic [CRC_W-1:0] POLY = 32'h04C11DB7;

   logic [CRC_W-1:0] base_c;
   logic [CRC_W-1:0] next_c;

   always_comb begin
      base_c = init ? '1 : crc;
      next_c = base_c;
      for (int i = 0; i < int'(BYTE_W); i++) begin
         next_c = {next_c[CRC_W-2:0], 1'b0} ^ ((next_c[CRC_W-1] ^ d[i]) ? POLY : '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       crc <= '1;
      else if (en)   crc <= next_c;
      else if (init) crc <= '1;
   end

endmodule

// File: rtl/udp_receive.sv
// GMII receiver: parses Ethernet/IPv4/UDP headers on the fly, streams the UDP
// payload of frames addressed to this node and flags FCS/rxer/truncation errors.
module udp_receive
   import udp_receive_pkg::*;
#(
   parameter logic [47:0] LOCAL_MAC  = 48'h000A3501FEC0,
   parameter logic [31:0] LOCAL_IP   = 32'hC0A80002,
   parameter logic [15:0] LOCAL_PORT = 16'h1F90
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rxdv,
   input  logic              rxer,
   input  logic [BYTE_W-1:0] rxd,
   output logic [BYTE_W-1:0] data_out,
   output logic              data_valid,
   output logic              frame_start,
   output logic              frame_done,
   output logic              frame_err,
   output logic [LEN_W-1:0]  rx_data_length,
   output logic [3:0]        rx_state
);

   rx_state_t         state, state_n;
   logic [IDX_W-1:0]  idx, idx_n;
   logic [LEN_W-1:0]  data_cnt, data_cnt_n;
   logic [2:0]        pad_cnt, pad_cnt_n;
   logic [LEN_W-1:0]  udp_len, udp_len_n;
   logic              uni_ok, uni_ok_n, bc_ok, bc_ok_n;
   logic              rxer_seen, rxer_seen_n;
   logic              rxdv_q;
   logic [BYTE_W-1:0] data_out_n;
   logic              data_valid_n, frame_start_n, frame_done_n, frame_err_n;
   logic [LEN_W-1:0]  rx_len_n;
   logic              crc_init_c, crc_en_c, uni_hit_c, bc_hit_c;
   logic [CRC_W-1:0]  crc;

   crc32_d8 u_crc (
      .clk  (clk),
      .rst  (rst),
      .init (crc_init_c),
      .en   (crc_en_c),
      .d    (rxd),
      .crc  (crc)
   );

   assign rx_state = state;

   // Next-state and registered-output logic.
   always_comb begin
      state_n       = state;
      idx_n         = idx;
      data_cnt_n    = data_cnt;
      pad_cnt_n     = pad_cnt;
      udp_len_n     = udp_len;
      uni_ok_n      = uni_ok;
      bc_ok_n       = bc_ok;
      rxer_seen_n   = rxer_seen;
      rx_len_n      = rx_data_length;
      data_out_n    = data_out;
      data_valid_n  = 1'b0;
      frame_start_n = 1'b0;
      frame_done_n  = 1'b0;
      frame_err_n   = 1'b0;
      crc_init_c    = 1'b0;
      crc_en_c      = rxdv && (state inside {ST_MAC, ST_HEADER, ST_DATA, ST_PAD_CRC});
      uni_hit_c     = uni_ok && (rxd == mac_byte(LOCAL_MAC, idx[2:0]));
      bc_hit_c      = bc_ok && (rxd == BCAST_BYTE);

      if (crc_en_c && rxer) rxer_seen_n = 1'b1;

      case (state)
         ST_IDLE: begin
            // rxdv_q guards against joining a frame already in flight after reset
            if (rxdv) begin
               state_n = (rxd == PREAMBLE_BYTE && !rxdv_q) ? ST_PREAMBLE : ST_DROP;
               idx_n   = IDX_W'(1);
            end
         end
         ST_PREAMBLE: begin
            if (!rxdv) state_n = ST_IDLE;
            else if (rxd == SFD_BYTE) begin
               state_n     = ST_MAC;
               idx_n       = '0;
               crc_init_c  = 1'b1;
               uni_ok_n    = 1'b1;
               bc_ok_n     = 1'b1;
               rxer_seen_n = 1'b0;
            end
            else if (rxd == PREAMBLE_BYTE && idx < IDX_W'(MAX_PREAMBLE)) idx_n = idx + IDX_W'(1);
            else state_n = ST_DROP;
         end
         ST_MAC: begin
            if (!rxdv) state_n = ST_IDLE;
            else begin
               idx_n = idx + IDX_W'(1);
               if (idx < IDX_W'(6)) begin
                  uni_ok_n = uni_hit_c;
                  bc_ok_n  = bc_hit_c;
                  if (!(uni_hit_c || bc_hit_c)) state_n = ST_DROP;
               end
               else if (idx == IDX_W'(12) && rxd != ETHERTYPE_IPV4[15:8]) state_n = ST_DROP;
               else if (idx == IDX_W'(MAC_BYTES - 1)) begin
                  idx_n   = '0;
                  state_n = (rxd == ETHERTYPE_IPV4[7:0]) ? ST_HEADER : ST_DROP;
               end
            end
         end
         ST_HEADER: begin
            if (!rxdv) state_n = ST_IDLE;
            else begin
               idx_n = idx + IDX_W'(1);
               case (idx)
                  IDX_W'(0):  if (rxd != IP_VER_IHL)        state_n = ST_DROP;
                  IDX_W'(9):  if (rxd != IP_PROTO_UDP)      state_n = ST_DROP;
                  IDX_W'(16): if (rxd != LOCAL_IP[31:24])   state_n = ST_DROP;
                  IDX_W'(17): if (rxd != LOCAL_IP[23:16])   state_n = ST_DROP;
                  IDX_W'(18): if (rxd != LOCAL_IP[15:8])    state_n = ST_DROP;
                  IDX_W'(19): if (rxd != LOCAL_IP[7:0])     state_n = ST_DROP;
                  IDX_W'(22): if (rxd != LOCAL_PORT[15:8])  state_n = ST_DROP;
                  IDX_W'(23): if (rxd != LOCAL_PORT[7:0])   state_n = ST_DROP;
                  IDX_W'(24): udp_len_n[15:8] = rxd;
                  IDX_W'(25): begin
                     udp_len_n[7:0] = rxd;
                     if ({udp_len[15:8], rxd} < UDP_HDR_LEN) state_n = ST_DROP;
                  end
                  IDX_W'(HDR_BYTES - 1): begin
                     rx_len_n   = udp_len - UDP_HDR_LEN;
                     data_cnt_n = '0;
                     pad_cnt_n  = '0;
                     state_n    = (udp_len == UDP_HDR_LEN) ? ST_PAD_CRC : ST_DATA;
                  end
                  default: ;
               endcase
            end
         end
         ST_DATA: begin
            if (!rxdv) begin
               frame_done_n = 1'b1;
               frame_err_n  = 1'b1;
               state_n      = ST_IDLE;
            end
            else begin
               data_out_n    = rxd;
               data_valid_n  = 1'b1;
               frame_start_n = (data_cnt == '0);
               data_cnt_n    = data_cnt + LEN_W'(1);
               if (data_cnt == rx_data_length - LEN_W'(1)) state_n = ST_PAD_CRC;
            end
         end
         ST_PAD_CRC: begin
            // pad_cnt saturates once the full FCS is known to have followed the payload
            if (!rxdv) begin
               frame_done_n = 1'b1;
               frame_err_n  = (crc != CRC_RESIDUE) || rxer_seen || (pad_cnt < 3'(FCS_BYTES));
               state_n      = ST_IDLE;
            end
            else if (pad_cnt < 3'(FCS_BYTES)) pad_cnt_n = pad_cnt + 3'd1;
         end
         ST_DROP: if (!rxdv) state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= ST_IDLE;
         idx            <= '0;
         data_cnt       <= '0;
         pad_cnt        <= '0;
         udp_len        <= '0;
         uni_ok         <= 1'b0;
         bc_ok          <= 1'b0;
         rxer_seen      <= 1'b0;
         rxdv_q         <= 1'b1;
         data_out       <= '0;
         data_valid     <= 1'b0;
         frame_start    <= 1'b0;
         frame_done     <= 1'b0;
         frame_err      <= 1'b0;
         rx_data_length <= '0;
      end
      else begin
         state          <= state_n;
         idx            <= idx_n;
         data_cnt       <= data_cnt_n;
         pad_cnt        <= pad_cnt_n;
         udp_len        <= udp_len_n;
         uni_ok         <= uni_ok_n;
         bc_ok          <= bc_ok_n;
         rxer_seen      <= rxer_seen_n;
         rxdv_q         <= rxdv;
         data_out       <= data_out_n;
         data_valid     <= data_valid_n;
         frame_start    <= frame_start_n;
         frame_done     <= frame_done_n;
         frame_err      <= frame_err_n;
         rx_data_length <= rx_len_n;
      end
   end

endmodule

// File: tb/tb_udp_receive.sv
// Scoreboard bench for udp_receive: frames are built byte-wise with a reflected
// CRC-32, a frame-level model predicts payload/done events, a monitor checks them.
module tb_udp_receive;

   localparam logic [47:0] LMAC  = 48'h000A3501FEC0;
   localparam logic [31:0] LIP   = 32'hC0A80002;
   localparam logic [15:0] LPORT = 16'h1F90;

   logic        clk = 1'b0;
   logic        rst, rxdv, rxer;
   logic [7:0]  rxd;
   logic [7:0]  data_out;
   logic        data_valid, frame_start, frame_done, frame_err;
   logic [15:0] rx_data_length;
   logic [3:0]  rx_state;

   udp_receive dut (
      .clk(clk), .rst(rst), .rxdv(rxdv), .rxer(rxer), .rxd(rxd),
      .data_out(data_out), .data_valid(data_valid), .frame_start(frame_start),
      .frame_done(frame_done), .frame_err(frame_err),
      .rx_data_length(rx_data_length), .rx_state(rx_state)
   );

   always #5 clk = ~clk;

   typedef struct { bit is_done; logic [7:0] data; bit start; bit err; } ev_t;

   ev_t         exp_q[$];
   logic [7:0]  fr[$];
   logic [7:0]  pl[$];
   int          n_assert = 0;
   int          n_fail = 0;
   logic [15:0] exp_len = '0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   function automatic logic [31:0] crc_upd(logic [31:0] c, logic [7:0] b);
      c = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      return c;
   endfunction

   function automatic void push_be(logic [63:0] v, int nb);
      for (int k = nb - 1; k >= 0; k--) fr.push_back(v[8*k +: 8]);
   endfunction

   function automatic void build(logic [47:0] dmac, logic [15:0] etype, logic [7:0] ver,
                                 logic [7:0] proto, logic [31:0] dip, logic [15:0] dport,
                                 logic [15:0] ulen, int pad);
      logic [31:0] c;
      fr.delete();
      push_be(dmac, 6); push_be(64'h0002_0304_0506, 6); push_be(etype, 2);
      fr.push_back(ver); fr.push_back(8'h00); push_be(64'(ulen) + 64'd20, 2);
      push_be(64'($urandom), 2); push_be(64'h4000, 2); fr.push_back(8'h40); fr.push_back(proto);
      push_be(64'h0, 2); push_be(64'hC0A80001, 4); push_be(dip, 4);
      push_be(64'd1234, 2); push_be(dport, 2); push_be(ulen, 2); push_be(64'h0, 2);
      foreach (pl[k]) fr.push_back(pl[k]);
      for (int k = 0; k < pad; k++) fr.push_back(8'h00);
      c = '1;
      foreach (fr[k]) c = crc_upd(c, fr[k]);
      c = ~c;
      for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
   endfunction

   // Frame-level expectation for pre_n preamble bytes, SFD and the first n bytes of fr.
   function automatic void model(int pre_n, int n, bit rxer_on);
      bit bc, uni, ok;
      int dl, avail, nout;
      logic [15:0] ulen;
      logic [31:0] c;
      if (pre_n < 1 || pre_n > 7 || n < 14) return;
      bc = 1; uni = 1;
      for (int k = 0; k < 6; k++) begin
         bc  = bc && (fr[k] == 8'hFF);
         uni = uni && (fr[k] == LMAC[8*(5-k) +: 8]);
      end
      if (!(bc || uni) || {fr[12], fr[13]} != 16'h0800 || n < 42) return;
      ok = fr[14] == 8'h45 && fr[23] == 8'h11 && {fr[30], fr[31], fr[32], fr[33]} == LIP
           && {fr[36], fr[37]} == LPORT;
      ulen = {fr[38], fr[39]};
      if (!ok || ulen < 16'd8) return;
      exp_len = ulen - 16'd8;
      dl = int'(exp_len);
      avail = n - 42;
      nout = (dl < avail) ? dl : avail;
      for (int k = 0; k < nout; k++) exp_q.push_back('{1'b0, fr[42+k], k == 0, 1'b0});
      if (avail < dl) exp_q.push_back('{1'b1, 8'h00, 1'b0, 1'b1});
      else begin
         c = '1;
         for (int k = 0; k < n; k++) c = crc_upd(c, fr[k]);
         exp_q.push_back('{1'b1, 8'h00, 1'b0, (c != 32'hDEBB20E3) || rxer_on || (avail - dl < 4)});
      end
   endfunction

   task automatic drive(input logic [7:0] b, input logic e);
      @(posedge clk); #1;
      rxdv = 1'b1; rxd = b; rxer = e;
   endtask

   task automatic check_reset_outputs();
      check("rst_data_out", data_out, 0);
      check("rst_data_valid", data_valid, 0);
      check("rst_frame_start", frame_start, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_rx_data_length", rx_data_length, 0);
      check("rst_rx_state", rx_state, 0);
   endtask

   task automatic do_reset();
      @(posedge clk); #6;
      rst = 1'b1;
      #1 check_reset_outputs();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic send(input int pre_n, input int n, input int rxer_pos, input int gap, input int rst_idx);
      for (int p = 0; p < pre_n; p++) drive(8'h55, 1'b0);
      drive(8'hD5, 1'b0);
      for (int k = 0; k < n; k++) begin
         if (k == rst_idx) do_reset();
         drive(fr[k], k == rxer_pos);
      end
      for (int g = 0; g < gap; g++) begin
         @(posedge clk); #1;
         rxdv = 1'b0; rxer = 1'b0; rxd = 8'h00;
      end
      if (gap >= 3) begin
         check("idle_after_frame", rx_state, 0);
         check("rx_data_length", rx_data_length, exp_len);
         check("scoreboard_drained", exp_q.size(), 0);
      end
   endtask

   task automatic ramp_payload(input int len);
      pl.delete();
      for (int k = 0; k < len; k++) pl.push_back(8'(k));
   endtask

   // Monitor: every output event must match the head of the scoreboard.
   always @(negedge clk) begin
      ev_t e;
      if (!rst) begin
         check("err_only_with_done", {31'b0, frame_err & ~frame_done}, 0);
         if (data_valid) begin
            if (exp_q.size() == 0) begin
               n_assert++; n_fail++;
               $display("FAIL unexpected_data: got %0h, expected no output", data_out);
            end else begin
               e = exp_q.pop_front();
               check("event_is_data", {31'b0, e.is_done}, 0);
               check("data_out", data_out, e.data);
               check("frame_start", frame_start, e.start);
            end
         end else if (frame_start) begin
            n_assert++; n_fail++;
            $display("FAIL frame_start_alone: got 1, expected 0");
         end
         if (frame_done) begin
            if (exp_q.size() == 0) begin
               n_assert++; n_fail++;
               $display("FAIL unexpected_done: got frame_done err=%0b, expected no output", frame_err);
            end else begin
               e = exp_q.pop_front();
               check("event_is_done", {31'b0, e.is_done}, 1);
               check("frame_err", frame_err, e.err);
            end
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, plen, pad, pre_n, n, rxer_pos, gap;
      logic [47:0] dmac;
      logic [15:0] ulen;
      rst = 1'b1; rxdv = 1'b0; rxer = 1'b0; rxd = 8'h00;
      repeat (3) @(posedge clk);
      #1 check_reset_outputs();
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // 1000-byte ramp, broadcast, good FCS
      ramp_payload(1000);
      build('1, 16'h0800, 8'h45, 8'h11, LIP, LPORT, 16'd1008, 0);
      model(7, fr.size(), 1'b0); send(7, fr.size(), -1, 4, -1);

      // same frame with one payload bit flipped
      build('1, 16'h0800, 8'h45, 8'h11, LIP, LPORT, 16'd1008, 0);
      fr[42+123] = fr[42+123] ^ 8'h10;
      model(7, fr.size(), 1'b0); send(7, fr.size(), -1, 4, -1);

      // wrong destination IP, then wrong port
      ramp_payload(20);
      build('1, 16'h0800, 8'h45, 8'h11, 32'hC0A80003, LPORT, 16'd28, 0);
      model(7, fr.size(), 1'b0); send(7, fr.size(), -1, 4, -1);
      build(LMAC, 16'h0800, 8'h45, 8'h11, LIP, 16'd8081, 16'd28, 0);
      model(7, fr.size(), 1'b0); send(7, fr.size(), -1, 4, -1);

      // two payload bytes plus 16 pad bytes
      pl.delete(); pl.push_back(8'hAA); pl.push_back(8'hBB);
      build(LMAC, 16'h0800, 8'h45, 8'h11, LIP, LPORT, 16'd10, 16);
      model(3, fr.size(), 1'b0); send(3, fr.size(), -1, 4, -1);

      // rxdv lost after 500 payload bytes, good frame 12 clk later
      ramp_payload(1000);
      build('1, 16'h0800, 8'h45, 8'h11, LIP, LPORT, 16'd1008, 0);
      model(7, 42 + 500, 1'b0); send(7, 42 + 500, -1, 12, -1);
      ramp_payload(64);
      build(LMAC, 16'h0800, 8'h45, 8'h11, LIP, LPORT, 16'd72, 0);
      model(7, fr.size(), 1'b0); send(7, fr.size(), -1, 4, -1);

      // reset at payload byte 300: bytes before it only, no frame_done
      ramp_payload(1000);
      build('1, 16'h0800, 8'h45, 8'h11, LIP, LPORT, 16'd1008, 0);
      model(7, 42 + 300, 1'b0);
      void'(exp_q.pop_back());
      exp_len = '0;
      send(7, fr.size(), -1, 4, 42 + 300);
      ramp_payload(30);
      build('1, 16'h0800, 8'h45, 8'h11, LIP, LPORT, 16'd38, 10);
      model(7, fr.size(), 1'b0); send(7, fr.size(), -1, 4, -1);

      // back-to-back with a single idle cycle
      ramp_payload(18);
      build(LMAC, 16'h0800, 8'h45, 8'h11, LIP, LPORT, 16'd26, 0);
      model(7, fr.size(), 1'b0); send(7, fr.size(), -1, 1, -1);
      model(1, fr.size(), 1'b0); send(1, fr.size(), -1, 4, -1);

      // randomized frames with header, preamble, FCS, rxer and truncation faults
      for (int k = 0; k < 40; k++) begin
         r = $urandom_range(0, 9);
         dmac = (r < 3) ? '1 : ((r < 9) ? LMAC : (LMAC ^ (48'h1 << $urandom_range(0, 47))));
         plen = $urandom_range(0, 40);
         ulen = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(0, 7)) : 16'(plen + 8);
         pad = $urandom_range(0, 20);
         pl.delete();
         for (int j = 0; j < plen; j++) pl.push_back(8'($urandom));
         build(dmac,
               ($urandom_range(0, 15) == 0) ? 16'h0806 : 16'h0800,
               ($urandom_range(0, 15) == 0) ? 8'h46 : 8'h45,
               ($urandom_range(0, 15) == 0) ? 8'h06 : 8'h11,
               ($urandom_range(0, 15) == 0) ? LIP + 32'd1 : LIP,
               ($urandom_range(0, 15) == 0) ? LPORT + 16'd1 : LPORT,
               ulen, pad);
         pre_n = ($urandom_range(0, 15) == 0) ? 8 : int'($urandom_range(1, 7));
         n = fr.size();
         if ($urandom_range(0, 7) == 0) n = $urandom_range(0, n - 1);
         if ($urandom_range(0, 7) == 0) begin
            r = $urandom_range(0, fr.size() - 1);
            fr[r] = fr[r] ^ 8'(1 << $urandom_range(0, 7));
         end
         rxer_pos = ($urandom_range(0, 9) == 0 && n > 0) ? int'($urandom_range(0, n - 1)) : -1;
         gap = $urandom_range(1, 4);
         model(pre_n, n, rxer_pos >= 0);
         send(pre_n, n, rxer_pos, gap, -1);
      end

      repeat (5) @(posedge clk);
      #1 check("final_scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/udp_receive.md
UDP_RECEIVE -- requirements
Module: udp_receive

Interface
REQ-001 SHALL have parameter LOCAL_MAC, default 48'h000A3501FEC0, unicast MAC accepted in addition to broadcast FF-FF-FF-FF-FF-FF.
REQ-002 SHALL have parameter LOCAL_IP, default 32'hC0A80002, the only accepted IPv4 destination address (192.168.0.2).
REQ-003 SHALL have parameter LOCAL_PORT, default 16'h1F90, the only accepted UDP destination port.
REQ-004 SHALL have port clk, input, 1, GMII receive clock; one clock only, all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port rxdv, input, 1, GMII receive data valid.
REQ-007 SHALL have port rxer, input, 1, GMII receive error.
REQ-008 SHALL have port rxd, input, 8, GMII receive data.
REQ-009 SHALL have port data_out, output, 8, UDP payload byte.
REQ-010 SHALL have port data_valid, output, 1, data_out qualifier.
REQ-011 SHALL have port frame_start, output, 1, one-cycle pulse coincident with the first payload byte.
REQ-012 SHALL have port frame_done, output, 1, one-cycle end-of-frame pulse for accepted frames.
REQ-013 SHALL have port frame_err, output, 1, qualifies frame_done: bad FCS, rxer seen, or truncation.
REQ-014 SHALL have port rx_data_length, output, 16, UDP length field minus 8, held until the next accepted header.
REQ-015 SHALL have port rx_state, output, 4, current state, for debug.

Function
REQ-016 SHALL implement states IDLE, PREAMBLE, MAC, HEADER, DATA, PAD_CRC and DROP.
REQ-017 IDLE SHALL move to PREAMBLE on rxdv=1 with rxd=8'h55.
- rxdv=1 with any other byte SHALL go to DROP.
REQ-018 PREAMBLE SHALL accept 1..7 bytes of 8'h55 followed by 8'hD5, then go to MAC.
- More than 7 bytes of 8'h55, or any other byte, SHALL go to DROP.
REQ-019 MAC SHALL capture 14 bytes and check two fields.
- Destination SHALL equal LOCAL_MAC or broadcast.
- Ethertype SHALL equal 16'h0800.
- A mismatch SHALL go to DROP at the byte that fails.
REQ-020 HEADER SHALL capture 28 bytes: IPv4 header then UDP header.
- Byte 0 SHALL equal 8'h45.
- Protocol SHALL equal 8'h11.
- Destination IP SHALL equal LOCAL_IP.
- Destination port SHALL equal LOCAL_PORT.
- UDP length SHALL be at least 8.
- A mismatch SHALL go to DROP.
- IP header checksum and UDP checksum SHALL NOT be checked.
REQ-021 On the last header byte, rx_data_length SHALL load UDP length minus 8.
- Go to DATA if the result is nonzero, else PAD_CRC.
REQ-022 In DATA, each rxd byte SHALL appear on data_out with data_valid=1 exactly one clk later.
- DATA SHALL output exactly rx_data_length bytes using a 16-bit counter, then go to PAD_CRC.
REQ-023 PAD_CRC SHALL consume pad and FCS bytes until rxdv=0, with data_valid=0.
REQ-024 CRC-32 (poly 04C11DB7, init FFFFFFFF, LSB-first) SHALL run over every byte from the first MAC byte to the last byte with rxdv=1.
- CRC SHALL be reinitialised on every SFD.
REQ-025 On rxdv falling in PAD_CRC, frame_done SHALL pulse one clk later and the state SHALL return to IDLE.
- frame_err SHALL be 1 in that cycle if the CRC register is not 32'hC704DD7B, if rxer was seen since SFD, or if fewer than 4 bytes followed the payload.
REQ-026 rxdv falling in DATA SHALL give a frame_done pulse with frame_err=1 and a return to IDLE.
REQ-027 rxdv falling in PREAMBLE, MAC or HEADER SHALL return to IDLE silently.
REQ-028 DROP SHALL wait for rxdv=0, then go to IDLE, with no outputs asserted.
REQ-029 IDLE SHALL require at least one rxdv=0 cycle between frames.
- Back-to-back frames with a one-cycle gap SHALL both be received.
REQ-030 frame_err SHALL be 0 whenever frame_done is 0.

Reset
REQ-031 rst SHALL act asynchronously and force state IDLE.
REQ-032 During reset, data_out, data_valid, frame_start, frame_done, frame_err, rx_data_length and rx_state SHALL all be 0.
REQ-033 rst mid-frame SHALL discard the frame with no frame_done pulse.
- After reset release, reception SHALL restart only at the next rxdv rising edge.

Structure
REQ-034 A shared package SHALL hold:
- state encoding;
- constants ETHERTYPE_IPV4=16'h0800, IP_PROTO_UDP=8'h11, CRC_RESIDUE=32'hC704DD7B, PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5.
REQ-035 The byte-wide CRC SHALL be a sub-module crc32_d8 with ports clk, rst, init, en, d[7:0] and crc[31:0].
- This sub-module SHALL be shareable with the transmit path.

Verification
REQ-036 Frame to 192.168.0.2:8080, broadcast MAC, UDP length 1008, 1000-byte ramp 00..E7, good FCS -> 1000 data_valid bytes matching the ramp, rx_data_length=1000, frame_done=1, frame_err=0.
REQ-037 Same frame with one payload bit flipped -> 1000 bytes out, frame_done=1, frame_err=1.
REQ-038 Destination IP 192.168.0.3 or destination port 8081 -> no data_valid, no frame_done, return to IDLE after rxdv falls.
REQ-039 UDP length 10, 2 payload bytes AA BB, 16 pad bytes, good FCS -> exactly 2 bytes out, frame_done=1, frame_err=0.
REQ-040 rxdv dropped after 500 payload bytes -> 500 bytes out, frame_done=1, frame_err=1; a following good frame 12 clk later -> received cleanly.
REQ-041 rst pulsed at payload byte 300 -> all outputs 0 immediately, no frame_done; a following good frame -> received cleanly.
